approx_mult_err_monitor: RTL and testbench
==========================================

// Module: approx_mult_err_monitor
// PURPOSE
//  Pipelined error-statistics collector placed directly downstream of the approximate log multiplier.
//  Consumes pairs of exact and approximate products and classifies each sample's relative error into LOW/MED/HIGH/SKY brackets.
//  Tracks the maximum relative error and the sample count, replacing the testbench real-number error loop in hardware.
// PARAMETERS
//  PROD_W   16  width of signed exact/approx products
//  CNT_W    32  width of every statistic counter (saturating)
//  LOW_PCT   1  LOW bracket upper bound, percent (strict <)
//  MED_PCT   5  MED bracket upper bound, percent (strict <)
//  HIGH_PCT 10  HIGH bracket upper bound, percent (strict <); at or above it is SKY
// PORTS
//  clk       in   1        clock, rising edge
//  rst_n     in   1        async active-low reset
//  clr       in   1        sync clear of all statistics (1-cycle pulse)
//  in_valid  in   1        exp_prod/apx_prod valid
//  in_ready  out  1        sample accepted when in_valid & in_ready
//  exp_prod  in   PROD_W   signed exact product A*B
//  apx_prod  in   PROD_W   signed approximate product
//  low_cnt   out  CNT_W    samples in LOW bracket
//  med_cnt   out  CNT_W    samples in MED bracket
//  high_cnt  out  CNT_W    samples in HIGH bracket
//  sky_cnt   out  CNT_W    samples in SKY bracket
//  smp_cnt   out  CNT_W    total accepted samples
//  max_num   out  PROD_W+1 |exp-apx| of max-error sample
//  max_den   out  PROD_W+1 |exp| of max-error sample (ratio = max error)
//  sat       out  1        sticky: a counter hit all-ones
//  busy      out  1        a sample is in the pipeline
// BEHAVIOUR
//  Reset: all counters 0, max_num=0, max_den=1, sat=0, busy=0, in_ready=0.
//   in_ready is 1 from the first clock after reset release.
//  in_ready = !clr. There is no other backpressure.
//   clr together with in_valid: clr wins; the sample is not accepted.
//  Stage 1 (accepted edge): register d=|exp-apx| (PROD_W+1 bits) and e=|exp|; stage-1 valid=1.
//  Stage 2: classify and update. All outputs reflect a sample 2 clocks after acceptance.
//   One sample per clock, fully pipelined.
//  Bracket rule, no divider:
//   LOW if d*100 < LOW_PCT*e; else MED if < MED_PCT*e; else HIGH if < HIGH_PCT*e; else SKY.
//  e==0: d==0 -> error 0 (LOW); d!=0 -> error 100% (SKY, candidate num=1, den=1).
//  Max update: replace when cand_num*max_den > max_num*cand_den (2*(PROD_W+1)-bit products, strict >).
//   On a tie the earlier sample is kept.
//  Counters saturate at all-ones. sat sets on any saturation and stays set until clr or reset.
//  clr: on the next edge, pipeline valid bits are dropped, counters are zeroed, and max is set to 0/1.
//   In-flight samples are discarded.
//  busy = stage-1 valid | stage-2 valid.
//  Reset asserted mid-stream: immediate return to reset values; partial statistics are lost.
// CONFIGURATION
//  `define ERRMON_MAE_EN: adds output sae_sum [CNT_W+PROD_W-1:0], the sum of d over all samples.
//   It saturates, follows the same 2-cycle latency, and is cleared by clr/reset (MAE = sae_sum/smp_cnt).
//  Without the macro: no sae_sum port and no accumulator logic.
// STRUCTURE
//  approx_mult_pkg holds:
//   - typedef prod_t (logic signed [PROD_W-1:0]) and mag_t (logic [PROD_W:0]);
//   - enum bracket_e {BR_LOW, BR_MED, BR_HIGH, BR_SKY};
//   - the default percent constants.
//  Sub-module errmon_bracket_cmp (combinational): inputs d and e, outputs bracket_e plus candidate num/den.
//   Instantiated in stage 2.
// TESTING
//  exp=100, apx=100 (one valid) -> low_cnt=1 and smp_cnt=1 exactly 2 clocks later; max stays 0/1.
//  exp=100, apx=93 -> high_cnt=1 (7%); max_num=7, max_den=100.
//  exp=-200, apx=-190 (exactly 5%) -> high_cnt=1, not med (strict <).
//  exp=0, apx=5 -> sky_cnt=1, max_num=1, max_den=1; a following exp=0, apx=0 -> low_cnt+1, max unchanged.
//  CNT_W=4, 16 back-to-back LOW samples -> low_cnt=15, smp_cnt=15, sat=1; then clr -> all 0, sat=0.
//  clr asserted with in_valid=1 and a sample in flight -> in_ready=0 that cycle; all counters 0 afterwards; busy=0.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared types and default constants for the approximate-multiplier error monitor.
package approx_mult_pkg;

  localparam int DEF_PROD_W   = 16;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_LOW_PCT  = 1;
  localparam int DEF_MED_PCT  = 5;
  localparam int DEF_HIGH_PCT = 10;

  typedef logic signed [DEF_PROD_W-1:0] prod_t;
  typedef logic [DEF_PROD_W:0]          mag_t;

  typedef enum logic [1:0] {BR_LOW, BR_MED, BR_HIGH, BR_SKY} bracket_e;

endpackage

// File: rtl/errmon_bracket_cmp.sv
// Divider-free relative-error classifier: compares d*100 against pct*e for each
// bracket bound and produces the error ratio as a num/den candidate pair.
module errmon_bracket_cmp
  import approx_mult_pkg::*;
#(
  parameter int PROD_W   = DEF_PROD_W,
  parameter int LOW_PCT  = DEF_LOW_PCT,
  parameter int MED_PCT  = DEF_MED_PCT,
  parameter int HIGH_PCT = DEF_HIGH_PCT
) (
  input  logic [PROD_W:0] d,
  input  logic [PROD_W:0] e,
  output bracket_e        bracket,
  output logic [PROD_W:0] cand_num,
  output logic [PROD_W:0] cand_den
);

  // Wide enough for d*100 and pct*e without overflow.
  localparam int SW = PROD_W + 16;

  logic [SW-1:0] d_scaled;
  logic [SW-1:0] low_lim;
  logic [SW-1:0] med_lim;
  logic [SW-1:0] high_lim;

  assign d_scaled = SW'(d) * SW'(100);
  assign low_lim  = SW'(e) * SW'(LOW_PCT);
  assign med_lim  = SW'(e) * SW'(MED_PCT);
  assign high_lim = SW'(e) * SW'(HIGH_PCT);

  // Pick the bracket; a zero exact product is either a perfect match or a 100% error.
  always_comb begin
    bracket  = BR_SKY;
    cand_num = d;
    cand_den = e;
    if (e == '0) begin
      cand_den = (PROD_W+1)'(1);
      if (d == '0) begin
        bracket  = BR_LOW;
        cand_num = '0;
      end else begin
        bracket  = BR_SKY;
        cand_num = (PROD_W+1)'(1);
      end
    end else if (d_scaled < low_lim) begin
      bracket = BR_LOW;
    end else if (d_scaled < med_lim) begin
      bracket = BR_MED;
    end else if (d_scaled < high_lim) begin
      bracket = BR_HIGH;
    end else begin
      bracket = BR_SKY;
    end
  end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Pipelined error-statistics collector for the approximate log multiplier.
// Stage 1 registers |exp-apx| and |exp|, stage 2 registers the bracket and
// ratio candidate, then the statistics update on the following edge.
// Optional feature: define ERRMON_MAE_EN to add the saturating sae_sum output.
module approx_mult_err_monitor
  import approx_mult_pkg::*;
#(
  parameter int PROD_W   = DEF_PROD_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOW_PCT  = DEF_LOW_PCT,
  parameter int MED_PCT  = DEF_MED_PCT,
  parameter int HIGH_PCT = DEF_HIGH_PCT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] exp_prod,
  input  logic [PROD_W-1:0] apx_prod,
  output logic [CNT_W-1:0]  low_cnt,
  output logic [CNT_W-1:0]  med_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  sky_cnt,
  output logic [CNT_W-1:0]  smp_cnt,
  output logic [PROD_W:0]   max_num,
  output logic [PROD_W:0]   max_den,
  output logic              sat,
  output logic              busy
`ifdef ERRMON_MAE_EN
  ,
  output logic [CNT_W+PROD_W-1:0] sae_sum
`endif
);

  localparam int MW = 2 * (PROD_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            ready_q;
  logic            accept;
  logic [PROD_W:0] exp_ext;
  logic [PROD_W:0] diff;
  logic [PROD_W:0] d_in;
  logic [PROD_W:0] e_in;

  logic            s1_valid;
  logic [PROD_W:0] s1_d;
  logic [PROD_W:0] s1_e;

  bracket_e        cmp_bracket;
  logic [PROD_W:0] cmp_num;
  logic [PROD_W:0] cmp_den;

  logic            s2_valid;
  bracket_e        s2_bracket;
  logic [PROD_W:0] s2_num;
  logic [PROD_W:0] s2_den;

  logic [CNT_W-1:0] low_nxt, med_nxt, high_nxt, sky_nxt, smp_nxt;
  logic [PROD_W:0]  max_num_nxt, max_den_nxt;
  logic [MW-1:0]    cand_cross, max_cross;
  logic             sat_nxt;

  assign in_ready = ready_q & ~clr;
  assign accept   = in_valid & in_ready;
  assign busy     = s1_valid | s2_valid;

  assign exp_ext = {exp_prod[PROD_W-1], exp_prod};
  assign diff    = exp_ext - {apx_prod[PROD_W-1], apx_prod};
  assign d_in    = diff[PROD_W] ? (~diff + (PROD_W+1)'(1)) : diff;
  assign e_in    = exp_ext[PROD_W] ? (~exp_ext + (PROD_W+1)'(1)) : exp_ext;

  // Ready comes up on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Stage 1: capture the error magnitude and the exact magnitude of an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_e     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_d <= d_in;
        s1_e <= e_in;
      end
    end
  end

  errmon_bracket_cmp #(
    .PROD_W   (PROD_W),
    .LOW_PCT  (LOW_PCT),
    .MED_PCT  (MED_PCT),
    .HIGH_PCT (HIGH_PCT)
  ) u_cmp (
    .d        (s1_d),
    .e        (s1_e),
    .bracket  (cmp_bracket),
    .cand_num (cmp_num),
    .cand_den (cmp_den)
  );

  // Stage 2: hold the classification so the statistics update sees registered values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_bracket <= BR_LOW;
      s2_num     <= '0;
      s2_den     <= '0;
    end else begin
      s2_valid <= s1_valid & ~clr;
      if (s1_valid) begin
        s2_bracket <= cmp_bracket;
        s2_num     <= cmp_num;
        s2_den     <= cmp_den;
      end
    end
  end

  assign cand_cross = MW'(s2_num) * MW'(max_den);
  assign max_cross  = MW'(max_num) * MW'(s2_den);

  // Next statistics: saturating bracket/sample counts and cross-multiplied max tracking.
  always_comb begin
    low_nxt     = low_cnt;
    med_nxt     = med_cnt;
    high_nxt    = high_cnt;
    sky_nxt     = sky_cnt;
    smp_nxt     = smp_cnt;
    max_num_nxt = max_num;
    max_den_nxt = max_den;
    if (s2_valid) begin
      if (smp_cnt != CNT_MAX) smp_nxt = smp_cnt + CNT_W'(1);
      case (s2_bracket)
        BR_LOW:  if (low_cnt  != CNT_MAX) low_nxt  = low_cnt  + CNT_W'(1);
        BR_MED:  if (med_cnt  != CNT_MAX) med_nxt  = med_cnt  + CNT_W'(1);
        BR_HIGH: if (high_cnt != CNT_MAX) high_nxt = high_cnt + CNT_W'(1);
        default: if (sky_cnt  != CNT_MAX) sky_nxt  = sky_cnt  + CNT_W'(1);
      endcase
      if (cand_cross > max_cross) begin
        max_num_nxt = s2_num;
        max_den_nxt = s2_den;
      end
    end
    sat_nxt = sat | (low_nxt == CNT_MAX) | (med_nxt == CNT_MAX) | (high_nxt == CNT_MAX)
                  | (sky_nxt == CNT_MAX) | (smp_nxt == CNT_MAX);
  end

  // Statistics registers; clr zeroes everything just like reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt  <= '0;
      med_cnt  <= '0;
      high_cnt <= '0;
      sky_cnt  <= '0;
      smp_cnt  <= '0;
      max_num  <= '0;
      max_den  <= (PROD_W+1)'(1);
      sat      <= 1'b0;
    end else if (clr) begin
      low_cnt  <= '0;
      med_cnt  <= '0;
      high_cnt <= '0;
      sky_cnt  <= '0;
      smp_cnt  <= '0;
      max_num  <= '0;
      max_den  <= (PROD_W+1)'(1);
      sat      <= 1'b0;
    end else begin
      low_cnt  <= low_nxt;
      med_cnt  <= med_nxt;
      high_cnt <= high_nxt;
      sky_cnt  <= sky_nxt;
      smp_cnt  <= smp_nxt;
      max_num  <= max_num_nxt;
      max_den  <= max_den_nxt;
      sat      <= sat_nxt;
    end
  end

`ifdef ERRMON_MAE_EN
  localparam int SAE_W = CNT_W + PROD_W;

  logic [PROD_W:0] s2_d;
  logic [SAE_W:0]  sae_wide;

  assign sae_wide = {1'b0, sae_sum} + (SAE_W+1)'(s2_d);

  // Carry the error magnitude alongside stage 2 for the absolute-error sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        s2_d <= '0;
    else if (s1_valid) s2_d <= s1_d;
  end

  // Saturating sum of absolute errors, updated with the other statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sae_sum <= '0;
    else if (clr)      sae_sum <= '0;
    else if (s2_valid) sae_sum <= sae_wide[SAE_W] ? '1 : sae_wide[SAE_W-1:0];
  end
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed-vector bench for approx_mult_err_monitor: a default instance and a
// 4-bit-counter instance share stimulus so saturation can be reached quickly.
module tb_approx_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] exp_prod = '0;
  logic [15:0] apx_prod = '0;

  logic        in_ready, sat, busy;
  logic [31:0] low_cnt, med_cnt, high_cnt, sky_cnt, smp_cnt;
  logic [16:0] max_num, max_den;

  logic        s_in_ready, s_sat, s_busy;
  logic [3:0]  s_low_cnt, s_med_cnt, s_high_cnt, s_sky_cnt, s_smp_cnt;
  logic [16:0] s_max_num, s_max_den;

`ifdef ERRMON_MAE_EN
  logic [47:0] sae_sum;
  logic [19:0] s_sae_sum;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  approx_mult_err_monitor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .exp_prod (exp_prod),
    .apx_prod (apx_prod),
    .low_cnt  (low_cnt),
    .med_cnt  (med_cnt),
    .high_cnt (high_cnt),
    .sky_cnt  (sky_cnt),
    .smp_cnt  (smp_cnt),
    .max_num  (max_num),
    .max_den  (max_den),
    .sat      (sat),
    .busy     (busy)
`ifdef ERRMON_MAE_EN
    ,
    .sae_sum  (sae_sum)
`endif
  );

  approx_mult_err_monitor #(.CNT_W(4)) dut_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (s_in_ready),
    .exp_prod (exp_prod),
    .apx_prod (apx_prod),
    .low_cnt  (s_low_cnt),
    .med_cnt  (s_med_cnt),
    .high_cnt (s_high_cnt),
    .sky_cnt  (s_sky_cnt),
    .smp_cnt  (s_smp_cnt),
    .max_num  (s_max_num),
    .max_den  (s_max_den),
    .sat      (s_sat),
    .busy     (s_busy)
`ifdef ERRMON_MAE_EN
    ,
    .sae_sum  (s_sae_sum)
`endif
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present one sample for one clock; returns on the negedge after it was accepted.
  task automatic applyStimulus(input logic [15:0] e, input logic [15:0] a);
    @(negedge clk);
    exp_prod = e;
    apx_prod = a;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearStats();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic checkStats(input string tag, input int lo, input int md, input int hi,
                            input int sk, input int sm, input int mn, input int mdn);
    checkOutput({tag, ".low"},  64'(low_cnt),  64'(lo));
    checkOutput({tag, ".med"},  64'(med_cnt),  64'(md));
    checkOutput({tag, ".high"}, 64'(high_cnt), 64'(hi));
    checkOutput({tag, ".sky"},  64'(sky_cnt),  64'(sk));
    checkOutput({tag, ".smp"},  64'(smp_cnt),  64'(sm));
    checkOutput({tag, ".mnum"}, 64'(max_num),  64'(mn));
    checkOutput({tag, ".mden"}, 64'(max_den),  64'(mdn));
  endtask

  task automatic sampleAndCheck(input string tag, input logic [15:0] e, input logic [15:0] a,
                                input int lo, input int md, input int hi,
                                input int sk, input int sm, input int mn, input int mdn);
    applyStimulus(e, a);
    waitCycles(2);
    checkStats(tag, lo, md, hi, sk, sm, mn, mdn);
  endtask

  initial begin
    waitCycles(2);
    checkStats("rst", 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rst.sat",   64'(sat),      64'(0));
    checkOutput("rst.busy",  64'(busy),     64'(0));
    checkOutput("rst.ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_up", 64'(in_ready), 64'(1));

    applyStimulus(16'd100, 16'd100);
    checkOutput("lat.busy", 64'(busy), 64'(1));
    @(negedge clk);
    checkOutput("lat.early_low", 64'(low_cnt), 64'(0));
    @(negedge clk);
    checkStats("exact", 1, 0, 0, 0, 1, 0, 1);
    checkOutput("lat.idle", 64'(busy), 64'(0));

    sampleAndCheck("pct7",   16'd100,   16'd93,   1, 0, 1, 0, 2, 7, 100);
    sampleAndCheck("pct5",   16'hFF38,  16'hFF42, 1, 0, 2, 0, 3, 7, 100);
    sampleAndCheck("zero_e", 16'd0,     16'd5,    1, 0, 2, 1, 4, 1, 1);
    sampleAndCheck("zero_z", 16'd0,     16'd0,    2, 0, 2, 1, 5, 1, 1);
    sampleAndCheck("pct3",   16'd100,   16'd97,   2, 1, 2, 1, 6, 1, 1);
    sampleAndCheck("pct1",   16'd1000,  16'd990,  2, 2, 2, 1, 7, 1, 1);
    sampleAndCheck("pct09",  16'd1000,  16'd991,  3, 2, 2, 1, 8, 1, 1);
    sampleAndCheck("pct10",  16'd100,   16'd110,  3, 2, 2, 2, 9, 1, 1);
    sampleAndCheck("tie",    16'd100,   16'd200,  3, 2, 2, 3, 10, 1, 1);
    sampleAndCheck("wide",   16'hFFFF,  16'h7FFF, 3, 2, 2, 4, 11, 32768, 1);
    checkOutput("wide.sat", 64'(sat), 64'(0));

    @(negedge clk);
    clr = 1'b1;
    #1 checkOutput("clr.ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    clr = 1'b0;
    checkStats("clr", 0, 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    exp_prod = 16'd50;
    apx_prod = 16'd50;
    in_valid = 1'b1;
    repeat (16) @(negedge clk);
    in_valid = 1'b0;
    waitCycles(2);
    checkOutput("burst.s_low", 64'(s_low_cnt), 64'(15));
    checkOutput("burst.s_smp", 64'(s_smp_cnt), 64'(15));
    checkOutput("burst.s_sat", 64'(s_sat),     64'(1));
    checkOutput("burst.s_med", 64'(s_med_cnt), 64'(0));
    checkOutput("burst.low",   64'(low_cnt),   64'(16));
    checkOutput("burst.smp",   64'(smp_cnt),   64'(16));
    checkOutput("burst.sat",   64'(sat),       64'(0));

    clearStats();
    checkOutput("sclr.s_low", 64'(s_low_cnt), 64'(0));
    checkOutput("sclr.s_smp", 64'(s_smp_cnt), 64'(0));
    checkOutput("sclr.s_sat", 64'(s_sat),     64'(0));

    @(negedge clk);
    exp_prod = 16'd100;
    apx_prod = 16'd93;
    in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    #1 checkOutput("flight.ready", 64'(in_ready), 64'(0));
    checkOutput("flight.busy", 64'(busy), 64'(1));
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    checkOutput("flight.busy0", 64'(busy), 64'(0));
    waitCycles(3);
    checkStats("flight", 0, 0, 0, 0, 0, 0, 1);
    checkOutput("flight.idle", 64'(busy), 64'(0));

    sampleAndCheck("pre_rst", 16'd100, 16'd93, 0, 0, 1, 0, 1, 7, 100);
    applyStimulus(16'd100, 16'd100);
    rst_n = 1'b0;
    #1;
    checkStats("midrst", 0, 0, 0, 0, 0, 0, 1);
    checkOutput("midrst.busy",  64'(busy),     64'(0));
    checkOutput("midrst.ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
